// File: rtl/wave_pkg.sv
// Shared types and sample-RAM geometry for the waveform display read path.
package wave_pkg;

  localparam int SAMPLE_ADDR_W = 9;
  localparam int SAMPLE_W      = 8;

  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    OPEN   = 2'd1,
    DRAIN  = 2'd2
  } arb_state_t;

  // Travels alongside each RAM read to steer the returning data.
  typedef struct packed {
    logic disp;
    logic ana;
    logic last;
  } rd_tag_t;

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register that delays read tags by the RAM read latency.
module tag_delay_line
  import wave_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    clear,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t tag_p [DEPTH];

  // Advance tags one stage per cycle; clear empties every stage
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) tag_p[i] <= '0;
    end else begin
      tag_p[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  assign tag_out = tag_p[DEPTH-1];

endmodule

// File: rtl/sample_read_arbiter.sv
// Shares the sample RAM read port: renderer always wins, analyzer is
// granted only while the display is blanking, returns stay in order.
module sample_read_arbiter
  import wave_pkg::*;
#(
  parameter int ADDR_W   = SAMPLE_ADDR_W,
  parameter int DATA_W   = SAMPLE_W,
  parameter int RD_LAT   = 1,
  parameter int STARVE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vsync,
  input  logic                disp_req,
  input  logic [ADDR_W-1:0]   disp_addr,
  output logic                disp_rvalid,
  output logic [DATA_W-1:0]   disp_rdata,
  input  logic                ana_req,
  input  logic [ADDR_W-1:0]   ana_addr,
  input  logic                ana_last,
  output logic                ana_gnt,
  output logic                ana_rvalid,
  output logic [DATA_W-1:0]   ana_rdata,
  output logic                ana_done,
  output logic [STARVE_W-1:0] starve_cnt,
  output logic [ADDR_W-1:0]   ram_addr,
  input  logic [DATA_W-1:0]   ram_rdata
);

  arb_state_t        state;
  logic              vsync_q;
  logic [1:0]        inflight;
  logic [ADDR_W-1:0] addr_hold;
  rd_tag_t           tag_in;
  rd_tag_t           tag_out;

  assign ana_gnt  = ana_req & ~disp_req & (state == OPEN);
  assign ram_addr = disp_req ? disp_addr : (ana_gnt ? ana_addr : addr_hold);

  // Remember the last issued address so an idle port does not glitch to 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) addr_hold <= '0;
    else       addr_hold <= ram_addr;
  end

  assign tag_in = '{disp: disp_req, ana: ana_gnt, last: ana_gnt & ana_last};

  tag_delay_line #(
    .DEPTH (RD_LAT)
  ) u_tag_delay_line (
    .clk     (clk),
    .clear   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Valids are masked while reset is high so the clear takes effect at once
  assign disp_rvalid = tag_out.disp & ~reset;
  assign ana_rvalid  = tag_out.ana & ~reset;
  assign ana_done    = ana_rvalid & tag_out.last;
  assign disp_rdata  = disp_rvalid ? ram_rdata : '0;
  assign ana_rdata   = ana_rvalid ? ram_rdata : '0;

  // Single synchroniser stage on vsync ahead of the state machine
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vsync_q <= 1'b1;
    else       vsync_q <= vsync;
  end

  // Count analyzer reads issued but not yet returned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({ana_gnt, ana_rvalid})
        2'b10:   inflight <= inflight + 2'd1;
        2'b01:   inflight <= inflight - 2'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Blanking window state machine; DRAIN waits for analyzer returns
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOCKED;
    end else begin
      case (state)
        LOCKED:  if (!vsync_q)         state <= OPEN;
        OPEN:    if (vsync_q)          state <= DRAIN;
        DRAIN:   if (inflight == 2'd0) state <= LOCKED;
        default:                       state <= LOCKED;
      endcase
    end
  end

  // Saturating wait counter for a pending, ungranted analyzer request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!ana_req || ana_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != '1) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

endmodule

// File: tb/tb_sample_read_arbiter.sv
// Directed bench for sample_read_arbiter with a 3-cycle RAM and 4-bit starvation counter.
module tb_sample_read_arbiter;
  import wave_pkg::*;

  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 8;
  localparam int RD_LAT   = 3;
  localparam int STARVE_W = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                vsync;
  logic                disp_req;
  logic [ADDR_W-1:0]   disp_addr;
  logic                disp_rvalid;
  logic [DATA_W-1:0]   disp_rdata;
  logic                ana_req;
  logic [ADDR_W-1:0]   ana_addr;
  logic                ana_last;
  logic                ana_gnt;
  logic                ana_rvalid;
  logic [DATA_W-1:0]   ana_rdata;
  logic                ana_done;
  logic [STARVE_W-1:0] starve_cnt;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_rdata;

  int errors = 0;
  int checks = 0;

  sample_read_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RD_LAT   (RD_LAT),
    .STARVE_W (STARVE_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .ana_req     (ana_req),
    .ana_addr    (ana_addr),
    .ana_last    (ana_last),
    .ana_gnt     (ana_gnt),
    .ana_rvalid  (ana_rvalid),
    .ana_rdata   (ana_rdata),
    .ana_done    (ana_done),
    .starve_cnt  (starve_cnt),
    .ram_addr    (ram_addr),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: content equals low address byte, three-cycle read latency
  logic [DATA_W-1:0] rd_p0, rd_p1, rd_p2;
  always @(posedge clk) begin
    rd_p0 <= ram_addr[7:0];
    rd_p1 <= rd_p0;
    rd_p2 <= rd_p1;
  end
  assign ram_rdata = rd_p2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; vsync = 1'b1;
    disp_req = 1'b0; disp_addr = '0;
    ana_req = 1'b0; ana_addr = '0; ana_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL rst_disp_rvalid got=%b exp=0", disp_rvalid); end
    checks++; if (ana_rvalid !== 1'b0) begin errors++; $display("FAIL rst_ana_rvalid got=%b exp=0", ana_rvalid); end
    checks++; if (ana_done !== 1'b0) begin errors++; $display("FAIL rst_ana_done got=%b exp=0", ana_done); end
    checks++; if (starve_cnt !== 4'd0) begin errors++; $display("FAIL rst_starve got=%0d exp=0", starve_cnt); end
    checks++; if (ram_addr !== 9'd0) begin errors++; $display("FAIL rst_ram_addr got=%0d exp=0", ram_addr); end
    checks++; if (dut.state !== LOCKED) begin errors++; $display("FAIL rst_state got=%0d exp=%0d", dut.state, LOCKED); end
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_renderer_only();
    logic ev;
    ana_req = 1'b1; ana_addr = 9'd300;
    for (int c = 0; c < 515; c++) begin
      cyc();
      if (c < 512) begin disp_req = 1'b1; disp_addr = 9'(c); end
      else disp_req = 1'b0;
      @(negedge clk);
      ev = (c >= RD_LAT);
      checks++; if (ana_gnt !== 1'b0) begin errors++; $display("FAIL rend_gnt c=%0d got=%b exp=0", c, ana_gnt); end
      checks++; if (ram_addr !== (c < 512 ? 9'(c) : 9'd511)) begin errors++; $display("FAIL rend_ram_addr c=%0d got=%0d", c, ram_addr); end
      checks++; if (disp_rvalid !== ev) begin errors++; $display("FAIL rend_rvalid c=%0d got=%b exp=%b", c, disp_rvalid, ev); end
      checks++; if (disp_rdata !== (ev ? 8'(c - RD_LAT) : 8'd0)) begin errors++; $display("FAIL rend_rdata c=%0d got=%0d", c, disp_rdata); end
    end
    ana_req = 1'b0;
  endtask

  task automatic test_blanking_burst();
    logic ev;
    cyc(); vsync = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    checks++; if (dut.state !== OPEN) begin errors++; $display("FAIL burst_open got=%0d exp=%0d", dut.state, OPEN); end
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (c < 4) begin ana_req = 1'b1; ana_addr = 9'(100 + c); ana_last = (c == 3); end
      else begin ana_req = 1'b0; ana_last = 1'b0; end
      @(negedge clk);
      ev = (c >= 3 && c <= 6);
      checks++; if (ana_gnt !== (c < 4)) begin errors++; $display("FAIL burst_gnt c=%0d got=%b", c, ana_gnt); end
      if (c < 4) begin
        checks++; if (ram_addr !== 9'(100 + c)) begin errors++; $display("FAIL burst_ram_addr c=%0d got=%0d exp=%0d", c, ram_addr, 100 + c); end
      end
      checks++; if (ana_rvalid !== ev) begin errors++; $display("FAIL burst_rvalid c=%0d got=%b exp=%b", c, ana_rvalid, ev); end
      checks++; if (ana_rdata !== (ev ? 8'(97 + c) : 8'd0)) begin errors++; $display("FAIL burst_rdata c=%0d got=%0d", c, ana_rdata); end
      checks++; if (ana_done !== (c == 6)) begin errors++; $display("FAIL burst_done c=%0d got=%b", c, ana_done); end
      checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL burst_disp_rvalid c=%0d got=%b exp=0", c, disp_rvalid); end
    end
  endtask

  task automatic test_collision();
    logic dv;
    for (int c = 0; c < 10; c++) begin
      cyc();
      disp_req = (c < 5); disp_addr = 9'd7;
      ana_req = (c <= 5); ana_addr = 9'd200; ana_last = 1'b1;
      @(negedge clk);
      dv = (c >= 3 && c <= 7);
      checks++; if (ana_gnt !== (c == 5)) begin errors++; $display("FAIL coll_gnt c=%0d got=%b", c, ana_gnt); end
      checks++; if (starve_cnt !== (c <= 5 ? 4'(c) : 4'd0)) begin errors++; $display("FAIL coll_starve c=%0d got=%0d", c, starve_cnt); end
      checks++; if (ram_addr !== (c < 5 ? 9'd7 : 9'd200)) begin errors++; $display("FAIL coll_ram_addr c=%0d got=%0d", c, ram_addr); end
      checks++; if (disp_rvalid !== dv) begin errors++; $display("FAIL coll_disp_rvalid c=%0d got=%b exp=%b", c, disp_rvalid, dv); end
      checks++; if (disp_rdata !== (dv ? 8'd7 : 8'd0)) begin errors++; $display("FAIL coll_disp_rdata c=%0d got=%0d", c, disp_rdata); end
      checks++; if (ana_rvalid !== (c == 8)) begin errors++; $display("FAIL coll_ana_rvalid c=%0d got=%b", c, ana_rvalid); end
      checks++; if (ana_rdata !== (c == 8 ? 8'd200 : 8'd0)) begin errors++; $display("FAIL coll_ana_rdata c=%0d got=%0d", c, ana_rdata); end
      checks++; if (ana_done !== (c == 8)) begin errors++; $display("FAIL coll_done c=%0d got=%b", c, ana_done); end
    end
    ana_req = 1'b0; ana_last = 1'b0;
  endtask

  task automatic test_drain_in_flight();
    arb_state_t es;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (c == 0) begin vsync = 1'b1; ana_req = 1'b1; ana_addr = 9'd55; ana_last = 1'b1; end
      else if (c == 1) begin ana_req = 1'b0; ana_last = 1'b0; end
      else begin ana_req = 1'b1; ana_addr = 9'd66; ana_last = 1'b0; end
      @(negedge clk);
      es = (c <= 1) ? OPEN : ((c <= 4) ? DRAIN : LOCKED);
      checks++; if (ana_gnt !== (c == 0)) begin errors++; $display("FAIL drain_gnt c=%0d got=%b", c, ana_gnt); end
      checks++; if (dut.state !== es) begin errors++; $display("FAIL drain_state c=%0d got=%0d exp=%0d", c, dut.state, es); end
      checks++; if (ana_rvalid !== (c == 3)) begin errors++; $display("FAIL drain_rvalid c=%0d got=%b", c, ana_rvalid); end
      checks++; if (ana_rdata !== (c == 3 ? 8'd55 : 8'd0)) begin errors++; $display("FAIL drain_rdata c=%0d got=%0d", c, ana_rdata); end
      checks++; if (ana_done !== (c == 3)) begin errors++; $display("FAIL drain_done c=%0d got=%b", c, ana_done); end
      checks++; if (ram_addr !== 9'd55) begin errors++; $display("FAIL drain_ram_addr c=%0d got=%0d exp=55", c, ram_addr); end
    end
    ana_req = 1'b0;
  endtask

  task automatic test_saturation();
    cyc(); ana_req = 1'b0;
    for (int c = 0; c < 22; c++) begin
      cyc();
      ana_req = 1'b1; ana_addr = 9'd1;
      @(negedge clk);
      checks++; if (starve_cnt !== (c < 15 ? 4'(c) : 4'd15)) begin errors++; $display("FAIL sat_starve c=%0d got=%0d", c, starve_cnt); end
      checks++; if (ana_gnt !== 1'b0) begin errors++; $display("FAIL sat_gnt c=%0d got=%b exp=0", c, ana_gnt); end
    end
    ana_req = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    cyc(); vsync = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    checks++; if (dut.state !== OPEN) begin errors++; $display("FAIL rmb_open got=%0d exp=%0d", dut.state, OPEN); end
    for (int c = 0; c < 3; c++) begin
      cyc();
      ana_req = 1'b1; ana_addr = 9'(10 + c); ana_last = 1'b0;
      disp_req = (c == 2); disp_addr = 9'd20;
      @(negedge clk);
      checks++; if (ana_gnt !== (c < 2)) begin errors++; $display("FAIL rmb_gnt c=%0d got=%b", c, ana_gnt); end
    end
    cyc();
    reset = 1'b1; disp_req = 1'b0; ana_req = 1'b0;
    @(negedge clk);
    checks++; if (ana_rvalid !== 1'b0) begin errors++; $display("FAIL rmb_ana_rvalid got=%b exp=0", ana_rvalid); end
    checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL rmb_disp_rvalid got=%b exp=0", disp_rvalid); end
    checks++; if (ana_done !== 1'b0) begin errors++; $display("FAIL rmb_done got=%b exp=0", ana_done); end
    checks++; if (starve_cnt !== 4'd0) begin errors++; $display("FAIL rmb_starve got=%0d exp=0", starve_cnt); end
    checks++; if (dut.state !== LOCKED) begin errors++; $display("FAIL rmb_state got=%0d exp=%0d", dut.state, LOCKED); end
    checks++; if (ram_addr !== 9'd0) begin errors++; $display("FAIL rmb_ram_addr got=%0d exp=0", ram_addr); end
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (c == 1) reset = 1'b0;
      @(negedge clk);
      checks++; if (ana_rvalid !== 1'b0) begin errors++; $display("FAIL rmb_stale_ana c=%0d got=%b exp=0", c, ana_rvalid); end
      checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL rmb_stale_disp c=%0d got=%b exp=0", c, disp_rvalid); end
    end
  endtask

  initial begin
    test_reset();
    test_renderer_only();
    test_blanking_burst();
    test_collision();
    test_drain_in_flight();
    test_saturation();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
